// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter phase monitor: legal ring codes,
// monitor state encoding and phase arithmetic.
package johnson_pkg;

  localparam int PHASE_W = 3;

  localparam logic [3:0] CODE_P0 = 4'b0000;
  localparam logic [3:0] CODE_P1 = 4'b1000;
  localparam logic [3:0] CODE_P2 = 4'b1100;
  localparam logic [3:0] CODE_P3 = 4'b1110;
  localparam logic [3:0] CODE_P4 = 4'b1111;
  localparam logic [3:0] CODE_P5 = 4'b0111;
  localparam logic [3:0] CODE_P6 = 4'b0011;
  localparam logic [3:0] CODE_P7 = 4'b0001;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    RESYNC   = 2'd2
  } mon_state_e;

  function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a sampled {Q1,Q2,Q3,Q4} ring code into phase,
// one-hot phase and a legality flag.
module johnson_decode
  import johnson_pkg::*;
(
  input  logic [3:0]         code,
  output logic [PHASE_W-1:0] phase,
  output logic [7:0]         phase_oh,
  output logic               valid
);

  always_comb begin
    valid    = 1'b1;
    phase    = '0;
    phase_oh = '0;
    case (code)
      CODE_P0: phase = 3'd0;
      CODE_P1: phase = 3'd1;
      CODE_P2: phase = 3'd2;
      CODE_P3: phase = 3'd3;
      CODE_P4: phase = 3'd4;
      CODE_P5: phase = 3'd5;
      CODE_P6: phase = 3'd6;
      CODE_P7: phase = 3'd7;
      default: valid = 1'b0;
    endcase
    if (valid) phase_oh[phase] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Samples a 4-bit Johnson ring, checks every step against the legal successor,
// locks onto a clean sequence and requests a counter clear when it is lost.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int RESYNC_LEN = 2,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               q1,
  input  logic               q2,
  input  logic               q3,
  input  logic               q4,
  input  logic               clr_err,
  output logic [PHASE_W-1:0] phase,
  output logic [7:0]         phase_oh,
  output logic               valid,
  output logic               locked,
  output logic               err,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               resync_n
);

  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [3:0]       RS_LAST   = 4'(RESYNC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [3:0]         cur;
  logic [3:0]         prev;
  logic               first;
  logic [3:0]         run;
  logic [3:0]         rs_cnt;
  mon_state_e         state;

  logic [PHASE_W-1:0] prev_phase;
  logic [7:0]         prev_oh;
  logic               prev_valid;
  logic               step_ok;
  logic               wrap;
  logic               err_evt;

  johnson_decode u_dec_cur (
    .code     (cur),
    .phase    (phase),
    .phase_oh (phase_oh),
    .valid    (valid)
  );

  johnson_decode u_dec_prev (
    .code     (prev),
    .phase    (prev_phase),
    .phase_oh (prev_oh),
    .valid    (prev_valid)
  );

  // A held code fails the successor test, so stalls are illegal steps too.
  always_comb begin
    step_ok = prev_valid && valid && (phase == next_phase(prev_phase));
    wrap    = step_ok && (prev_oh == 8'h80);
    err_evt = (state == LOCKED) && !step_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= '0;
      prev      <= '0;
      first     <= 1'b1;
      run       <= '0;
      rs_cnt    <= '0;
      state     <= UNLOCKED;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
      cycle_cnt <= '0;
      resync_n  <= 1'b1;
    end else begin
      cur   <= {q1, q2, q3, q4};
      prev  <= cur;
      first <= 1'b0;

      // An error in the same cycle as clr_err restarts the count at one.
      if (err_evt) begin
        err <= 1'b1;
        if (clr_err)           err_cnt <= CNT_ONE;
        else if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end

      case (state)
        UNLOCKED: begin
          if (!first) begin
            if (!step_ok) begin
              run <= '0;
            end else if (run == LOCK_LAST) begin
              run    <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end else begin
              run <= run + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (!step_ok) begin
            state    <= RESYNC;
            locked   <= 1'b0;
            resync_n <= 1'b0;
            rs_cnt   <= '0;
          end else if (wrap) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end
        RESYNC: begin
          if (rs_cnt == RS_LAST) begin
            state    <= UNLOCKED;
            resync_n <= 1'b1;
            first    <= 1'b1;
            run      <= '0;
          end else begin
            rs_cnt <= rs_cnt + 1'b1;
          end
        end
        default: begin
          state    <= UNLOCKED;
          locked   <= 1'b0;
          resync_n <= 1'b1;
          run      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed scoreboard bench for johnson_phase_monitor: expectations are queued
// as each stimulus step is driven and checked just after the following clock edge.
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       q1, q2, q3, q4;
  logic       clr_err;
  logic [2:0] phase;
  logic [7:0] phase_oh;
  logic       valid, locked, err;
  logic [7:0] err_cnt, cycle_cnt;
  logic       resync_n;

  always #5 clk = ~clk;

  johnson_phase_monitor #(
    .LOCK_CNT   (4),
    .RESYNC_LEN (2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .clr_err   (clr_err),
    .phase     (phase),
    .phase_oh  (phase_oh),
    .valid     (valid),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt),
    .cycle_cnt (cycle_cnt),
    .resync_n  (resync_n)
  );

  typedef enum int {S_PHASE, S_OH, S_VALID, S_LOCKED, S_ERR, S_ERRCNT, S_CYC, S_RSN} sig_e;
  typedef struct {
    string      tag;
    sig_e       sig;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};
  int         t5_seq [10] = '{7, 0, 1, 2, 4, 5, 6, 7, 0, 1};

  function automatic logic [7:0] observe(input sig_e s);
    logic [7:0] r;
    r = '0;
    case (s)
      S_PHASE:  r = {5'b0, phase};
      S_OH:     r = phase_oh;
      S_VALID:  r = {7'b0, valid};
      S_LOCKED: r = {7'b0, locked};
      S_ERR:    r = {7'b0, err};
      S_ERRCNT: r = err_cnt;
      S_CYC:    r = cycle_cnt;
      S_RSN:    r = {7'b0, resync_n};
      default:  r = '0;
    endcase
    return r;
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare_all();
    exp_t       e;
    logic [7:0] obs;
    while (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic set_q(input logic [3:0] c);
    {q1, q2, q3, q4} = c;
  endtask

  task automatic push_reset_vals(input string pfx);
    push({pfx, "_phase"},  S_PHASE,  8'd0);
    push({pfx, "_oh"},     S_OH,     8'h01);
    push({pfx, "_valid"},  S_VALID,  8'd1);
    push({pfx, "_locked"}, S_LOCKED, 8'd0);
    push({pfx, "_err"},    S_ERR,    8'd0);
    push({pfx, "_errcnt"}, S_ERRCNT, 8'd0);
    push({pfx, "_cyc"},    S_CYC,    8'd0);
    push({pfx, "_rsn"},    S_RSN,    8'd1);
  endtask

  // Counter held cleared while resync is low, then runs 1..5 to relock.
  task automatic resync_relock(input bit chk);
    set_q(4'b0000);
    if (chk) push("rs_low2", S_RSN, 8'd0);
    tick();
    set_q(4'b0000);
    if (chk) begin
      push("rs_release", S_RSN, 8'd1);
      push("rs_unlocked", S_LOCKED, 8'd0);
    end
    tick();
    for (int p = 1; p <= 5; p++) begin
      set_q(codes[p]);
      if (chk && p == 4) push("relock_early", S_LOCKED, 8'd0);
      if (chk && p == 5) push("relock", S_LOCKED, 8'd1);
      tick();
    end
  endtask

  task automatic cycle_error(input bit chk, input bit clr, input logic [7:0] ecnt);
    set_q(4'b1010);
    if (chk) begin
      push("bad_valid", S_VALID, 8'd0);
      push("bad_phase", S_PHASE, 8'd0);
      push("bad_oh", S_OH, 8'd0);
      push("bad_locked", S_LOCKED, 8'd1);
    end
    tick();
    set_q(4'b0000);
    clr_err = clr;
    if (chk) begin
      push("err_flag", S_ERR, 8'd1);
      push("err_cnt", S_ERRCNT, ecnt);
      push("err_unlock", S_LOCKED, 8'd0);
      push("rs_low1", S_RSN, 8'd0);
    end
    tick();
    clr_err = 1'b0;
    resync_relock(chk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset values, lock-up and cycle counting
    rst = 1'b1;
    clr_err = 1'b0;
    set_q(4'b0000);
    #12;
    push_reset_vals("rst");
    settle();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      set_q(codes[(k-1) % 8]);
      push("t1_phase", S_PHASE, 8'((k-1) % 8));
      push("t1_oh", S_OH, 8'(1 << ((k-1) % 8)));
      push("t1_valid", S_VALID, 8'd1);
      if (k == 5) push("t1_prelock", S_LOCKED, 8'd0);
      if (k == 6) push("t1_lock", S_LOCKED, 8'd1);
      if (k >= 7) begin
        push("t1_rsn", S_RSN, 8'd1);
        push("t1_err", S_ERR, 8'd0);
      end
      if (k == 9)  push("t1_cyc0", S_CYC, 8'd0);
      if (k == 10) push("t1_cyc1", S_CYC, 8'd1);
      if (k == 22) push("t1_cyc2", S_CYC, 8'd2);
      tick();
    end

    // Test 2: one illegal code while locked
    cycle_error(1'b1, 1'b0, 8'd1);

    // Test 3: stall at 1100 while locked
    set_q(codes[6]); tick();
    set_q(codes[7]); tick();
    set_q(codes[0]); tick();
    set_q(codes[1]);
    push("t3_cyc", S_CYC, 8'd3);
    tick();
    set_q(codes[2]); tick();
    set_q(codes[2]);
    push("t3_prestall_locked", S_LOCKED, 8'd1);
    push("t3_phase", S_PHASE, 8'd2);
    tick();
    set_q(codes[3]);
    push("t3_err", S_ERR, 8'd1);
    push("t3_errcnt", S_ERRCNT, 8'd2);
    push("t3_unlock", S_LOCKED, 8'd0);
    push("t3_rsn", S_RSN, 8'd0);
    tick();
    resync_relock(1'b1);

    // Test 4: saturation and clear
    for (int i = 0; i < 300; i++) cycle_error(1'b0, 1'b0, 8'd0);
    push("t4_sat", S_ERRCNT, 8'd255);
    push("t4_err", S_ERR, 8'd1);
    push("t4_cyc", S_CYC, 8'd3);
    settle();
    set_q(codes[6]);
    clr_err = 1'b1;
    push("t4_clr_err", S_ERR, 8'd0);
    push("t4_clr_cnt", S_ERRCNT, 8'd0);
    push("t4_clr_locked", S_LOCKED, 8'd1);
    tick();
    clr_err = 1'b0;
    cycle_error(1'b1, 1'b1, 8'd1);

    // Test 6: reset in the middle of the resync pulse
    push("t6_cyc_before", S_CYC, 8'd3);
    settle();
    set_q(4'b1010);
    tick();
    set_q(4'b0000);
    push("t6_rsn_low", S_RSN, 8'd0);
    tick();
    #2;
    rst = 1'b1;
    push_reset_vals("t6");
    settle();
    @(negedge clk);
    rst = 1'b0;

    // Test 5: skipped code while unlocked with three legal steps counted
    for (int e = 1; e <= 10; e++) begin
      set_q(codes[t5_seq[e-1]]);
      if (e == 6) begin
        push("t5_skip_err", S_ERR, 8'd0);
        push("t5_skip_locked", S_LOCKED, 8'd0);
      end
      if (e == 7) push("t5_run_reset", S_LOCKED, 8'd0);
      if (e == 9) push("t5_prelock", S_LOCKED, 8'd0);
      if (e == 10) begin
        push("t5_lock", S_LOCKED, 8'd1);
        push("t5_cyc", S_CYC, 8'd0);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
